// File: rtl/bsg_fpu_pkg.sv
// Shared FPU package: default mantissa width and the count-width helper
// used by the leading-digit counter and normaliser.
package bsg_fpu_pkg;

    localparam int fpu_mant_width_gp = 32;

    // Bits needed to hold a leading-digit count of 0..w inclusive.
    function automatic int lzc_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bsg_fpu_normalize_pipe_if.sv
// Valid/ready bundle for the normaliser: producer side (v/data/ones/ready)
// and consumer side (v/data/count/zero/yumi).
interface bsg_fpu_normalize_pipe_if
    import bsg_fpu_pkg::*;
#(
    parameter int width_p = fpu_mant_width_gp,
    localparam int cnt_width_lp = lzc_cnt_width(width_p)
);

    logic                    v_i;
    logic [width_p-1:0]      data_i;
    logic                    ones_i;
    logic                    ready_o;
    logic                    v_o;
    logic [width_p-1:0]      data_o;
    logic [cnt_width_lp-1:0] count_o;
    logic                    zero_o;
    logic                    yumi_i;

    modport slave (
        input  v_i, data_i, ones_i, yumi_i,
        output ready_o, v_o, data_o, count_o, zero_o
    );

    modport master (
        output v_i, data_i, ones_i, yumi_i,
        input  ready_o, v_o, data_o, count_o, zero_o
    );

endinterface

// File: rtl/bsg_fpu_normalize_pipe_lzc.sv
// Combinational leading-zero counter, MSB-first priority encode.
// Returns width_p when the input is all zero.
module bsg_fpu_lzc
    import bsg_fpu_pkg::*;
#(
    parameter int width_p = fpu_mant_width_gp,
    localparam int cnt_width_lp = lzc_cnt_width(width_p)
) (
    input  logic [width_p-1:0]      i,
    output logic [cnt_width_lp-1:0] count_o
);

    // Ascending scan: the highest set bit is the last one to write.
    always_comb begin
        count_o = cnt_width_lp'(width_p);
        for (int k = 0; k < width_p; k++) begin
            if (i[k]) count_o = cnt_width_lp'(width_p - 1 - k);
        end
    end

endmodule

// File: rtl/bsg_fpu_normalize_pipe.sv
// Two-stage normaliser: S1 counts leading digits, S2 barrel-shifts the
// mantissa so its leading significant bit lands at the MSB.
module bsg_fpu_normalize_pipe
    import bsg_fpu_pkg::*;
#(
    parameter int width_p = fpu_mant_width_gp,
    localparam int cnt_width_lp = lzc_cnt_width(width_p)
) (
    input logic                      clk_i,
    input logic                      reset_i,
    bsg_fpu_normalize_pipe_if.slave  io
);

    logic                    v1_q, v2_q;
    logic                    ready1, ready2;
    logic [width_p-1:0]      data1_q, data2_q, data2_d;
    logic [cnt_width_lp-1:0] cnt1_q, cnt1_d, cnt2_q;
    logic                    zero1_q, zero1_d, zero2_q;
    logic [width_p-1:0]      lzc_in;

    assign ready2     = ~v2_q | io.yumi_i;
    assign ready1     = ~v1_q | ready2;
    assign io.ready_o = ready1 & ~reset_i;

    // Counting leading ones is counting leading zeros of the complement.
    assign lzc_in = io.ones_i ? ~io.data_i : io.data_i;

    bsg_fpu_lzc #(.width_p(width_p)) lzc (
        .i       (lzc_in),
        .count_o (cnt1_d)
    );

    assign zero1_d = (cnt1_d == cnt_width_lp'(width_p));

    // Log2 shifter layers; layer l shifts by 2**l when count bit l is set.
    logic [width_p-1:0] shl [cnt_width_lp+1];
    assign shl[0] = data1_q;

    for (genvar l = 0; l < cnt_width_lp; l++) begin : g_shl
        assign shl[l+1] = cnt1_q[l] ? (shl[l] << (2 ** l)) : shl[l];
    end

    assign data2_d = zero1_q ? '0 : shl[cnt_width_lp];

    // ones_i only steers the counter; the shift is zero-fill in both modes,
    // so the raw operand is all S2 needs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            cnt1_q  <= '0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            data2_q <= '0;
            cnt2_q  <= '0;
            zero2_q <= 1'b0;
        end else begin
            if (ready1) begin
                v1_q    <= io.v_i;
                data1_q <= io.data_i;
                cnt1_q  <= cnt1_d;
                zero1_q <= zero1_d;
            end
            if (ready2) begin
                v2_q    <= v1_q;
                data2_q <= data2_d;
                cnt2_q  <= cnt1_q;
                zero2_q <= zero1_q;
            end
        end
    end

    assign io.v_o     = v2_q;
    assign io.data_o  = data2_q;
    assign io.count_o = cnt2_q;
    assign io.zero_o  = zero2_q;

endmodule

// File: tb/tb_bsg_fpu_normalize_pipe.sv
// Scoreboard bench for bsg_fpu_normalize_pipe at width_p = 16 with
// directed vectors and hand-computed results.
module tb_bsg_fpu_normalize_pipe;

    localparam int W  = 16;
    localparam int CW = 5;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [CW-1:0] count;
        logic          zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic yumi_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    res_t sb[$];

    bsg_fpu_normalize_pipe_if #(.width_p(W)) io ();

    bsg_fpu_normalize_pipe #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Consumer: takes whatever is presented while enabled.
    initial begin
        io.yumi_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            io.yumi_i = yumi_en & io.v_o;
        end
    end

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        res_t got, exp;
        forever begin
            @(negedge clk);
            if (io.v_o === 1'b1 && io.yumi_i === 1'b1) begin
                got = '{io.data_o, io.count_o, io.zero_o};
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL result_unexpected: got %h with nothing pending", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL result: got data=%h cnt=%0d z=%b want data=%h cnt=%0d z=%b",
                                 got.data, got.count, got.zero, exp.data, exp.count, exp.zero);
                    end
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting posedge with v_i still high.
    task automatic send(input logic [W-1:0] d, input logic ones,
                        input logic [W-1:0] ed, input int ec, input logic ez);
        int n = 0;
        io.v_i    = 1'b1;
        io.data_i = d;
        io.ones_i = ones;
        forever begin
            @(negedge clk);
            if (io.ready_o === 1'b1) break;
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL send_timeout: ready_o stuck low, want 1");
                io.v_i = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back('{ed, CW'(ec), ez});
        #1;
    endtask

    task automatic idle();
        io.v_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        io.v_i = 1'b0; io.data_i = '0; io.ones_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_v_o",     32'(io.v_o),     0);
        check("rst_ready_o", 32'(io.ready_o), 0);
        check("rst_data_o",  32'(io.data_o),  0);
        check("rst_count_o", 32'(io.count_o), 0);
        check("rst_zero_o",  32'(io.zero_o),  0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(io.ready_o), 1);

        // Latency: accepted on edge N, visible after N+2.
        yumi_en = 1'b1;
        send(16'h0340, 1'b0, 16'hD000, 6, 1'b0);
        idle();
        @(negedge clk);
        check("lat_n1_v_o", 32'(io.v_o), 0);
        @(negedge clk);
        check("lat_n2_v_o", 32'(io.v_o), 1);
        @(posedge clk); #1;
        drain("drain_latency");

        // Directed vectors back to back at full rate.
        send(16'h0000, 1'b0, 16'h0000, 16, 1'b1);
        send(16'hFFFF, 1'b1, 16'h0000, 16, 1'b1);
        send(16'hFC12, 1'b1, 16'h0480, 6,  1'b0);
        send(16'h8000, 1'b0, 16'h8000, 0,  1'b0);
        send(16'h0001, 1'b0, 16'h8000, 15, 1'b0);
        send(16'h7FFF, 1'b1, 16'h7FFF, 0,  1'b0);
        send(16'hFFFE, 1'b1, 16'h0000, 15, 1'b0);
        send(16'h0001, 1'b1, 16'h0001, 0,  1'b0);
        idle();
        drain("drain_vectors");

        // Backpressure: two accepts fill the pipe, the third is held.
        yumi_en = 1'b0;
        send(16'h1234, 1'b0, 16'h91A0, 3, 1'b0);
        send(16'h00F0, 1'b0, 16'hF000, 8, 1'b0);
        io.data_i = 16'hC005; io.ones_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(io.ready_o), 0);
            check("bp_v_o",       32'(io.v_o),     1);
            check("bp_data_hold", 32'(io.data_o),  32'h91A0);
            check("bp_cnt_hold",  32'(io.count_o), 3);
        end
        @(posedge clk); #1;
        yumi_en = 1'b1;
        send(16'hC005, 1'b1, 16'h0014, 2, 1'b0);
        idle();
        drain("drain_backpressure");

        // Asynchronous reset with both stages full.
        yumi_en = 1'b0;
        send(16'h0F00, 1'b0, 16'hF000, 4, 1'b0);
        send(16'h4000, 1'b0, 16'h8000, 1, 1'b0);
        idle();
        #2;
        check("pre_rst_full", 32'(io.v_o), 1);
        rst = 1'b1;
        #1;
        check("arst_v_o",     32'(io.v_o),     0);
        check("arst_ready_o", 32'(io.ready_o), 0);
        check("arst_data_o",  32'(io.data_o),  0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready_o", 32'(io.ready_o), 1);
        check("rel_v_o",     32'(io.v_o),     0);
        repeat (2) @(negedge clk);
        check("rel_v_o_idle", 32'(io.v_o), 0);
        @(posedge clk); #1;
        yumi_en = 1'b1;
        send(16'h0003, 1'b0, 16'hC000, 14, 1'b0);
        idle();
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
